uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART: one transmitter and one independent receiver sharing one clock.
- Sits between a byte-level parallel interface and a serial line pair.
- Bit timing is fixed by the CLKS_PER_BIT parameter (10 MHz / 115200 baud = 87).
- TX and RX operate concurrently with no interaction; a bench may loop o_TX_Serial back to i_RX_Serial.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit; legal range is 4 or more.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_TX_DV  in  1  transmit request; sampled only while TX idle
- i_TX_Byte  in  8  byte to send; captured in the cycle i_TX_DV is accepted
- o_TX_Active  out  1  high while a frame is being driven
- o_TX_Serial  out  1  serial output; idles high
- o_TX_Done  out  1  one-cycle pulse at end of stop bit
- i_RX_Serial  in  1  asynchronous serial input; idles high
- o_RX_DV  out  1  one-cycle pulse when a valid byte is received
- o_RX_Byte  out  8  last valid received byte; held until the next valid frame

Behaviour:
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly CLKS_PER_BIT cycles; a frame lasts 10*CLKS_PER_BIT cycles.
- Reset (asynchronous, any time, including mid-frame): both FSMs go to IDLE and counters clear.
  - Output values during reset: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=0.
  - The synchronizer flops reset to 1.
- TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: o_TX_Serial=1. If i_TX_DV=1 at a rising edge, latch i_TX_Byte and go to START.
  - o_TX_Active=1 and o_TX_Serial=0 take effect from that same edge (all outputs registered).
  - START holds 0 for CLKS_PER_BIT cycles.
  - DATA drives bit index 0..7 for CLKS_PER_BIT cycles each, using a 3-bit index.
  - STOP drives 1 for CLKS_PER_BIT cycles. On its last cycle, o_TX_Done pulses for one cycle and o_TX_Active drops.
  - CLEANUP lasts one cycle, then the FSM returns to IDLE.
  - i_TX_DV is ignored in every non-IDLE state. Changes to i_TX_Byte after acceptance have no effect.
- RX input: i_RX_Serial passes through a 2-flop synchronizer. All RX decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: a synchronized 0 moves the FSM to START.
  - START: wait (CLKS_PER_BIT-1)/2 cycles to reach mid-bit. If the line is still 0, clear the counter and go to DATA; otherwise the start is a glitch and the FSM returns to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample into bit index 0..7 (LSB first); after bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - If 1: update o_RX_Byte and pulse o_RX_DV for exactly one cycle.
    - If 0 (framing error): discard the byte; o_RX_DV stays low and o_RX_Byte is unchanged.
  - CLEANUP lasts one cycle, then the FSM returns to IDLE. A new start bit is not recognised before IDLE.
- Counter width is $clog2(CLKS_PER_BIT)+1 bits. Counters never wrap mid-bit and reset to 0 on every bit boundary.
- o_RX_DV and o_TX_Done are never asserted for more than one consecutive cycle.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_BITS=8
  - the TX and RX state enum typedefs
  - a function returning the counter width for a given CLKS_PER_BIT
- Natural sub-modules: uart_tx and uart_rx, each parameterised by CLKS_PER_BIT, instantiated side by side in uart_transceiver.
- The synchronizer lives inside uart_rx.

Test Plan:
- Loopback 0x3F: CLKS_PER_BIT=87, 100 ns clock, o_TX_Serial looped to i_RX_Serial, i_TX_DV pulsed one cycle with i_TX_Byte=0x3F → o_RX_DV single pulse within 10 bit periods of start; o_RX_Byte=0x3F.
- TX waveform 0xAB: o_TX_Serial sampled at each mid-bit → 0,1,1,0,1,0,1,0,1,1. Each bit lasts 87 cycles. o_TX_Done pulses once. o_TX_Active is high for 870 cycles.
- Busy ignore: during an 0x55 frame, assert i_TX_DV with 0xFF → the transmitted frame remains 0x55 and only one o_TX_Done pulse occurs.
- RX glitch: drive i_RX_Serial low for 20 cycles, then high → no o_RX_DV; the FSM returns to IDLE and a following 0xA5 frame is received correctly.
- Framing error: drive a 0x12 frame with stop bit 0 → no o_RX_DV; o_RX_Byte keeps its previous value.
- Reset mid-frame: assert i_Reset halfway through a TX frame → o_TX_Serial=1, o_TX_Active=0, o_RX_DV=0, o_RX_Byte=0 immediately. After release, a new 0xC3 loopback passes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_CLEANUP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } rx_state_t;

  // One spare bit so the bit-period counter comfortably holds CLKS_PER_BIT-1.
  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit) + 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a 2-flop input synchronizer and mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);

  rx_state_t            r_state, n_state;
  logic [CW-1:0]        r_count, n_count;
  logic [2:0]           r_index, n_index;
  logic [DATA_BITS-1:0] r_shift, n_shift;
  logic [7:0]           n_byte;
  logic                 n_dv;
  logic                 r_rx_meta, r_rx_sync;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_state   <= RX_IDLE;
      r_count   <= '0;
      r_index   <= '0;
      r_shift   <= '0;
      o_RX_Byte <= '0;
      o_RX_DV   <= 1'b0;
    end else begin
      r_rx_meta <= i_RX_Serial;
      r_rx_sync <= r_rx_meta;
      r_state   <= n_state;
      r_count   <= n_count;
      r_index   <= n_index;
      r_shift   <= n_shift;
      o_RX_Byte <= n_byte;
      o_RX_DV   <= n_dv;
    end
  end

  // A start bit that is gone by mid-bit is treated as line noise and dropped.
  always_comb begin
    n_state = r_state;
    n_count = r_count;
    n_index = r_index;
    n_shift = r_shift;
    n_byte  = o_RX_Byte;
    n_dv    = 1'b0;
    case (r_state)
      RX_IDLE: begin
        n_count = '0;
        n_index = '0;
        if (!r_rx_sync) n_state = RX_START;
      end
      RX_START: begin
        if (r_count == MID_CNT) begin
          n_count = '0;
          n_state = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          n_count = r_count + CW'(1);
        end
      end
      RX_DATA: begin
        if (r_count == LAST_CNT) begin
          n_count          = '0;
          n_shift[r_index] = r_rx_sync;
          if (r_index == 3'd7) begin
            n_index = '0;
            n_state = RX_STOP;
          end else begin
            n_index = r_index + 3'd1;
          end
        end else begin
          n_count = r_count + CW'(1);
        end
      end
      RX_STOP: begin
        if (r_count == LAST_CNT) begin
          n_count = '0;
          if (r_rx_sync) begin
            n_byte = r_shift;
            n_dv   = 1'b1;
          end
          n_state = RX_CLEANUP;
        end else begin
          n_count = r_count + CW'(1);
        end
      end
      RX_CLEANUP: n_state = RX_IDLE;
      default:    n_state = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; every output is registered, so the line changes on the accepting edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  tx_state_t            r_state, n_state;
  logic [CW-1:0]        r_count, n_count;
  logic [2:0]           r_index, n_index;
  logic [DATA_BITS-1:0] r_data,  n_data;
  logic                 n_serial, n_active, n_done;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= TX_IDLE;
      r_count     <= '0;
      r_index     <= '0;
      r_data      <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      r_state     <= n_state;
      r_count     <= n_count;
      r_index     <= n_index;
      r_data      <= n_data;
      o_TX_Serial <= n_serial;
      o_TX_Active <= n_active;
      o_TX_Done   <= n_done;
    end
  end

  // Outputs are computed one cycle ahead so they line up with the state they belong to.
  always_comb begin
    n_state  = r_state;
    n_count  = r_count;
    n_index  = r_index;
    n_data   = r_data;
    n_serial = o_TX_Serial;
    n_active = o_TX_Active;
    n_done   = 1'b0;
    case (r_state)
      TX_IDLE: begin
        n_serial = 1'b1;
        n_active = 1'b0;
        n_count  = '0;
        n_index  = '0;
        if (i_TX_DV) begin
          n_data   = i_TX_Byte;
          n_serial = 1'b0;
          n_active = 1'b1;
          n_state  = TX_START;
        end
      end
      TX_START: begin
        if (r_count == LAST_CNT) begin
          n_count  = '0;
          n_serial = r_data[0];
          n_state  = TX_DATA;
        end else begin
          n_count = r_count + CW'(1);
        end
      end
      TX_DATA: begin
        if (r_count == LAST_CNT) begin
          n_count = '0;
          if (r_index == 3'd7) begin
            n_index  = '0;
            n_serial = 1'b1;
            n_state  = TX_STOP;
          end else begin
            n_index  = r_index + 3'd1;
            n_serial = r_data[n_index];
          end
        end else begin
          n_count = r_count + CW'(1);
        end
      end
      TX_STOP: begin
        if (r_count == LAST_CNT) begin
          n_count  = '0;
          n_done   = 1'b1;
          n_active = 1'b0;
          n_state  = TX_CLEANUP;
        end else begin
          n_count = r_count + CW'(1);
        end
      end
      TX_CLEANUP: n_state = TX_IDLE;
      default:    n_state = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver on one clock.
module uart_transceiver #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_TX_DV     (i_TX_DV),
    .i_TX_Byte   (i_TX_Byte),
    .o_TX_Active (o_TX_Active),
    .o_TX_Serial (o_TX_Serial),
    .o_TX_Done   (o_TX_Done)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_RX_Serial (i_RX_Serial),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: table-driven loopback frames plus RX and reset corner cases.
module tb_uart_transceiver;

  localparam int CPB          = 87;
  localparam int FRAME_CYCLES = 10 * CPB;
  localparam int RUN_CYCLES   = FRAME_CYCLES + 20;

  typedef struct {
    logic [7:0] txByte;
    logic [9:0] frame;
    logic [7:0] rxByte;
    logic       busyPoke;
  } vector_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       txDv;
  logic [7:0] txByte;
  logic       txActive;
  logic       txSerial;
  logic       txDone;
  logic       rxSerial;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       loopback;
  logic       rxLine;

  int compared   = 0;
  int mismatched = 0;
  int rxDvCount  = 0;
  int doneCount  = 0;
  int rxDvDouble = 0;
  int doneDouble = 0;
  logic prevRxDv = 1'b0;
  logic prevDone = 1'b0;

  vector_t vectors[5];

  always #50 clock = ~clock;

  assign rxSerial = loopback ? txSerial : rxLine;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clock),
    .i_Reset     (reset),
    .i_TX_DV     (txDv),
    .i_TX_Byte   (txByte),
    .o_TX_Active (txActive),
    .o_TX_Serial (txSerial),
    .o_TX_Done   (txDone),
    .i_RX_Serial (rxSerial),
    .o_RX_DV     (rxDv),
    .o_RX_Byte   (rxByte)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clock) begin
    if (rxDv) rxDvCount++;
    if (txDone) doneCount++;
    if (rxDv && prevRxDv) rxDvDouble++;
    if (txDone && prevDone) doneDouble++;
    prevRxDv = rxDv;
    prevDone = txDone;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sends one byte from TX (optionally poking i_TX_DV mid-frame) and checks waveform, pulses and loopback result.
  task automatic applyStimulus(input vector_t v);
    logic [9:0] seen;
    int activeCycles;
    int dvStart;
    int doneStart;
    seen         = '0;
    activeCycles = 0;
    dvStart      = rxDvCount;
    doneStart    = doneCount;
    @(negedge clock);
    txDv   = 1'b1;
    txByte = v.txByte;
    for (int c = 0; c < RUN_CYCLES; c++) begin
      @(negedge clock);
      if (c == 0) begin
        txDv   = 1'b0;
        txByte = ~v.txByte;
      end
      if (v.busyPoke && c == 300) begin
        txDv   = 1'b1;
        txByte = 8'hFF;
      end
      if (v.busyPoke && c == 305) txDv = 1'b0;
      if (txActive) activeCycles++;
      for (int k = 0; k < 10; k++)
        if (c == k * CPB + CPB / 2) seen[9 - k] = txSerial;
    end
    @(posedge clock);
    #1;
    checkOutput($sformatf("frame_%02h", v.txByte), {22'd0, seen}, {22'd0, v.frame});
    checkOutput($sformatf("active_cycles_%02h", v.txByte), activeCycles, FRAME_CYCLES);
    checkOutput($sformatf("done_pulses_%02h", v.txByte), doneCount - doneStart, 1);
    checkOutput($sformatf("rx_dv_pulses_%02h", v.txByte), rxDvCount - dvStart, 1);
    checkOutput($sformatf("rx_byte_%02h", v.txByte), {24'd0, rxByte}, {24'd0, v.rxByte});
  endtask

  task automatic driveRxFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxLine = bits[k];
      repeat (CPB) @(negedge clock);
    end
    rxLine = 1'b1;
  endtask

  initial begin
    int dvStart;

    // Frames listed in line order: start bit first, stop bit last.
    vectors[0] = '{txByte: 8'h3F, frame: 10'b0111111001, rxByte: 8'h3F, busyPoke: 1'b0};
    vectors[1] = '{txByte: 8'hAB, frame: 10'b0110101011, rxByte: 8'hAB, busyPoke: 1'b0};
    vectors[2] = '{txByte: 8'h55, frame: 10'b0101010101, rxByte: 8'h55, busyPoke: 1'b1};
    vectors[3] = '{txByte: 8'h00, frame: 10'b0000000001, rxByte: 8'h00, busyPoke: 1'b0};
    vectors[4] = '{txByte: 8'hFF, frame: 10'b0111111111, rxByte: 8'hFF, busyPoke: 1'b0};

    reset    = 1'b1;
    txDv     = 1'b0;
    txByte   = 8'h00;
    loopback = 1'b1;
    rxLine   = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_tx_serial", {31'd0, txSerial}, 32'd1);
    checkOutput("reset_tx_active", {31'd0, txActive}, 32'd0);
    checkOutput("reset_tx_done",   {31'd0, txDone},   32'd0);
    checkOutput("reset_rx_dv",     {31'd0, rxDv},     32'd0);
    checkOutput("reset_rx_byte",   {24'd0, rxByte},   32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    foreach (vectors[i]) applyStimulus(vectors[i]);

    // Short low pulse on RX must be rejected, then a real frame must still be received.
    loopback = 1'b0;
    rxLine   = 1'b1;
    repeat (10) @(negedge clock);
    dvStart = rxDvCount;
    rxLine  = 1'b0;
    repeat (20) @(negedge clock);
    rxLine = 1'b1;
    repeat (200) @(negedge clock);
    checkOutput("glitch_no_dv", rxDvCount - dvStart, 0);
    dvStart = rxDvCount;
    driveRxFrame(8'hA5, 1'b1);
    repeat (50) @(negedge clock);
    checkOutput("after_glitch_dv", rxDvCount - dvStart, 1);
    checkOutput("after_glitch_byte", {24'd0, rxByte}, 32'h0000_00A5);

    // Stop bit sampled low: byte discarded, previous byte kept.
    dvStart = rxDvCount;
    driveRxFrame(8'h12, 1'b0);
    repeat (200) @(negedge clock);
    checkOutput("framing_no_dv", rxDvCount - dvStart, 0);
    checkOutput("framing_byte_held", {24'd0, rxByte}, 32'h0000_00A5);

    // Asynchronous reset halfway through a loopback frame.
    loopback = 1'b1;
    @(negedge clock);
    txDv   = 1'b1;
    txByte = 8'h55;
    @(negedge clock);
    txDv = 1'b0;
    repeat (434) @(negedge clock);
    checkOutput("midframe_active_before", {31'd0, txActive}, 32'd1);
    #10;
    reset = 1'b1;
    #1;
    checkOutput("midreset_tx_serial", {31'd0, txSerial}, 32'd1);
    checkOutput("midreset_tx_active", {31'd0, txActive}, 32'd0);
    checkOutput("midreset_rx_dv",     {31'd0, rxDv},     32'd0);
    checkOutput("midreset_rx_byte",   {24'd0, rxByte},   32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    applyStimulus('{txByte: 8'hC3, frame: 10'b0110000111, rxByte: 8'hC3, busyPoke: 1'b0});

    checkOutput("rx_dv_never_double", rxDvDouble, 0);
    checkOutput("tx_done_never_double", doneDouble, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
